// File: rtl/qpsk_frame_ctrl.sv
// Frame sequencer feeding the QPSK modulator serial input: preamble, sync word, length byte, payload.
// Optional feature macro QPSK_CRC_EN appends a CRC-8 (poly 0x07, init 0x00) over the length and payload bytes.
module qpsk_frame_ctrl #(
    parameter int         BIT_CLKS  = 4,
    parameter int         PRE_BITS  = 16,
    parameter logic [7:0] SYNC_WORD = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] len,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       bit_out,
    output logic       tx_active,
    output logic       bit_stb,
    output logic       done,
    output logic       underrun
);
    localparam int            PW       = $clog2(BIT_CLKS);
    localparam logic [PW-1:0] PH_LAST  = PW'(BIT_CLKS - 1);
    localparam logic [6:0]    PRE_LAST = 7'(PRE_BITS - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_SYNC = 3'd2;
    localparam logic [2:0] S_LEN  = 3'd3;
    localparam logic [2:0] S_PAY  = 3'd4;
`ifdef QPSK_CRC_EN
    localparam logic [2:0] S_CRC  = 3'd5;

    logic [7:0] crc;
    logic [7:0] crc_nxt;
    // CRC advances by the bit currently on the line, so it is ready on the last payload edge
    assign crc_nxt = {crc[6:0], 1'b0} ^ ({8{crc[7] ^ bit_out}} & 8'h07);
`endif

    logic [PW-1:0] ph;
    logic [2:0]    state;
    logic [6:0]    bcnt;
    logic [7:0]    sh;
    logic [7:0]    len_q;
    logic [7:0]    hold;
    logic [7:0]    taken;
    logic [7:0]    pay_cnt;
    logic          full;
    logic          pending;

    assign bit_stb = (ph == PH_LAST);
    assign s_ready = (state == S_SYNC || state == S_LEN || state == S_PAY) && !full && (taken < len_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            ph        <= '0;
            state     <= S_IDLE;
            bcnt      <= '0;
            sh        <= '0;
            len_q     <= '0;
            hold      <= '0;
            taken     <= '0;
            pay_cnt   <= '0;
            full      <= 1'b0;
            pending   <= 1'b0;
            bit_out   <= 1'b0;
            tx_active <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
`ifdef QPSK_CRC_EN
            crc       <= '0;
`endif
        end else begin
            done     <= 1'b0;
            underrun <= 1'b0;
            ph       <= (ph == PH_LAST) ? '0 : ph + 1'b1;

            if (s_valid && s_ready) begin
                hold  <= s_data;
                full  <= 1'b1;
                taken <= taken + 8'd1;
            end

            if (state == S_IDLE && start && !pending) begin
                pending <= 1'b1;
                len_q   <= len;
            end

            if (bit_stb) begin
`ifdef QPSK_CRC_EN
                if (state == S_LEN || state == S_PAY)
                    crc <= crc_nxt;
`endif
                case (state)
                    S_IDLE: begin
                        if (start || pending) begin
                            pending   <= 1'b0;
                            if (!pending)
                                len_q <= len;
                            state     <= S_PRE;
                            bcnt      <= PRE_LAST;
                            bit_out   <= 1'b1;
                            tx_active <= 1'b1;
                            taken     <= '0;
                            pay_cnt   <= '0;
                            full      <= 1'b0;
`ifdef QPSK_CRC_EN
                            crc       <= '0;
`endif
                        end
                    end
                    S_PRE: begin
                        if (bcnt != '0) begin
                            bit_out <= ~bit_out;
                            bcnt    <= bcnt - 7'd1;
                        end else begin
                            state   <= S_SYNC;
                            bit_out <= SYNC_WORD[7];
                            sh      <= {SYNC_WORD[6:0], 1'b0};
                            bcnt    <= 7'd7;
                        end
                    end
                    S_SYNC: begin
                        if (bcnt != '0) begin
                            bit_out <= sh[7];
                            sh      <= {sh[6:0], 1'b0};
                            bcnt    <= bcnt - 7'd1;
                        end else begin
                            state   <= S_LEN;
                            bit_out <= len_q[7];
                            sh      <= {len_q[6:0], 1'b0};
                            bcnt    <= 7'd7;
                        end
                    end
                    // LEN and PAY share the byte-boundary logic; pay_cnt is 0 while in LEN
                    S_LEN, S_PAY: begin
                        if (bcnt != '0) begin
                            bit_out <= sh[7];
                            sh      <= {sh[6:0], 1'b0};
                            bcnt    <= bcnt - 7'd1;
                        end else if (pay_cnt == len_q) begin
`ifdef QPSK_CRC_EN
                            state   <= S_CRC;
                            bit_out <= crc_nxt[7];
                            sh      <= {crc_nxt[6:0], 1'b0};
                            bcnt    <= 7'd7;
`else
                            state     <= S_IDLE;
                            bit_out   <= 1'b0;
                            tx_active <= 1'b0;
                            done      <= 1'b1;
`endif
                        end else if (full) begin
                            state   <= S_PAY;
                            bit_out <= hold[7];
                            sh      <= {hold[6:0], 1'b0};
                            full    <= 1'b0;
                            pay_cnt <= pay_cnt + 8'd1;
                            bcnt    <= 7'd7;
                        end else begin
                            state     <= S_IDLE;
                            bit_out   <= 1'b0;
                            tx_active <= 1'b0;
                            full      <= 1'b0;
                            underrun  <= 1'b1;
                        end
                    end
`ifdef QPSK_CRC_EN
                    S_CRC: begin
                        if (bcnt != '0) begin
                            bit_out <= sh[7];
                            sh      <= {sh[6:0], 1'b0};
                            bcnt    <= bcnt - 7'd1;
                        end else begin
                            state     <= S_IDLE;
                            bit_out   <= 1'b0;
                            tx_active <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        state     <= S_IDLE;
                        bit_out   <= 1'b0;
                        tx_active <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_qpsk_frame_ctrl.sv
// Bench for qpsk_frame_ctrl: frame-level reference model (bit list per frame, accepted-byte queue)
// checked every cycle, plus literal expectations for reset, phase, directed frames and abort cases.
module tb_qpsk_frame_ctrl;
    localparam int         BC = 4;
    localparam int         PB = 16;
    localparam logic [7:0] SW = 8'hA5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] len = '0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready, bit_out, tx_active, bit_stb, done, underrun;

    qpsk_frame_ctrl #(.BIT_CLKS(BC), .PRE_BITS(PB), .SYNC_WORD(SW)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .bit_out(bit_out), .tx_active(tx_active), .bit_stb(bit_stb),
        .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model: clocks since reset, frame as an explicit bit list, bytes accepted upstream
    int         cyc = 0;
    bit         m_act = 0, m_pend = 0, m_done = 0, m_und = 0, m_crc_sent = 0, e_ready = 0;
    logic [7:0] m_len = '0;
    int         m_k = 0, m_cons = 0;
    bit         m_bits[$];
    logic [7:0] m_acc[$];

    bit         obs[$];
    int         n_act, n_done, n_und, n_rdy;
    logic [7:0] payload[16];

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r = c ^ b;
        for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        return r;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) m_bits.push_back(b[i]);
    endtask

    task automatic model_edge();
        bit stb = (cyc == BC - 1);
        bit hs  = s_valid && e_ready;
        logic [7:0] c;
        m_done = 0;
        m_und  = 0;
        if (!reset) begin
            cyc = 0; m_act = 0; m_pend = 0; m_k = 0; m_cons = 0; e_ready = 0;
            m_bits.delete(); m_acc.delete();
            return;
        end
        cyc = (cyc + 1) % BC;
        if (m_act && stb) begin
            m_k++;
            if (m_k == m_bits.size()) begin
                if (m_cons < int'(m_len)) begin
                    if (m_acc.size() > m_cons) begin
                        push_byte(m_acc[m_cons]);
                        m_cons++;
                    end else begin
                        m_und = 1;
                        m_act = 0;
                    end
                end
`ifdef QPSK_CRC_EN
                else if (!m_crc_sent) begin
                    c = crc8(8'h00, m_len);
                    foreach (m_acc[i]) c = crc8(c, m_acc[i]);
                    push_byte(c);
                    m_crc_sent = 1;
                end
`endif
                else begin
                    m_done = 1;
                    m_act  = 0;
                end
            end
        end else if (!m_act) begin
            if (stb && (start || m_pend)) begin
                if (!m_pend) m_len = len;
                m_pend = 0; m_act = 1; m_k = 0; m_cons = 0; m_crc_sent = 0;
                m_bits.delete(); m_acc.delete();
                for (int i = 0; i < PB; i++) m_bits.push_back(~i[0]);
                push_byte(SW);
                push_byte(m_len);
            end else if (start && !m_pend) begin
                m_pend = 1;
                m_len  = len;
            end
        end
        if (hs && m_act) m_acc.push_back(s_data);
        e_ready = m_act && (m_k >= PB) && (m_acc.size() == m_cons) && (m_acc.size() < int'(m_len));
    endtask

    task automatic check_cycle();
        logic [5:0] got, want;
        got  = {bit_out, tx_active, bit_stb, done, underrun, s_ready};
        want = {(m_act ? m_bits[m_k] : 1'b0), m_act, (cyc == BC - 1), m_done, m_und, e_ready};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL cycle t=%0t {bit,act,stb,done,und,rdy} got %b want %b", $time, got, want);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [63:0] obs_val(input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n && i < obs.size(); i++) v = {v[62:0], obs[i]};
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_cycle();
        if (tx_active && bit_stb) obs.push_back(bit_out);
        if (tx_active) n_act++;
        if (done) n_done++;
        if (underrun) n_und++;
        if (s_ready) n_rdy++;
    endtask

    task automatic run_frame(input int L, input int vpct, input int stop_at, input int abort_after, input bit stray);
        int idx = 0;
        int c;
        bit hs;
        obs.delete();
        n_act = 0; n_done = 0; n_und = 0; n_rdy = 0;
        start = 1'b1;
        len = 8'(L);
        s_valid = 1'b0;
        step();
        start = 1'b0;
        for (c = 0; c < 800; c++) begin
            s_valid = (idx < stop_at) && (idx < L) && (int'($urandom_range(99)) < vpct);
            s_data  = s_valid ? payload[idx] : 8'($urandom);
            if (stray) begin
                start = ($urandom_range(40) == 0);
                len   = 8'($urandom_range(5));
            end
            hs = s_valid && s_ready;
            step();
            if (hs) idx++;
            if (n_done != 0 || n_und != 0) break;
            if (abort_after != 0 && c >= abort_after) break;
        end
        start = 1'b0;
        s_valid = 1'b0;
        if (c == 800) chk("frame_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        logic [7:0] pat = '0;
        int L, stop;
        for (int i = 0; i < 16; i++) payload[i] = 8'($urandom);

        for (int i = 0; i < 5; i++) step();
        chk("reset_outputs", 64'({bit_out, tx_active, bit_stb, done, underrun, s_ready}), 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            pat = {pat[6:0], bit_stb};
        end
        chk("stb_pattern", 64'(pat), 64'h22);

        payload[0] = 8'h3C; payload[1] = 8'hF0;
        run_frame(2, 100, 2, 0, 0);
`ifdef QPSK_CRC_EN
        chk("t2_bits_len", 64'(obs.size()), 64'd56);
        chk("t2_act_clks", 64'(n_act), 64'd224);
`else
        chk("t2_bits_len", 64'(obs.size()), 64'd48);
        chk("t2_act_clks", 64'(n_act), 64'd192);
`endif
        chk("t2_bits", obs_val(48), 64'hAAAA_A502_3CF0);
        chk("t2_done", 64'(n_done), 64'd1);

        run_frame(0, 100, 0, 0, 0);
`ifdef QPSK_CRC_EN
        chk("t3_bits_len", 64'(obs.size()), 64'd40);
`else
        chk("t3_bits_len", 64'(obs.size()), 64'd32);
`endif
        chk("t3_bits", obs_val(32), 64'hAAAA_A500);
        chk("t3_ready_cycles", 64'(n_rdy), 64'd0);
        chk("t3_done", 64'(n_done), 64'd1);

        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
        run_frame(3, 100, 2, 0, 0);
        chk("t4_underrun", 64'(n_und), 64'd1);
        chk("t4_no_done", 64'(n_done), 64'd0);
        chk("t4_act_clks", 64'(n_act), 64'd192);
        step();
        chk("t4_idle_after", 64'(tx_active), 64'd0);
        for (int i = 0; i < 3; i++) step();

        payload[0] = 8'h5A; payload[1] = 8'h66; payload[2] = 8'h99; payload[3] = 8'hC3;
        run_frame(4, 100, 4, 176, 0);
        chk("t5_midframe_active", 64'(tx_active), 64'd1);
        reset = 1'b0;
        step();
        chk("t5_reset_outputs", 64'({bit_out, tx_active, bit_stb, done, underrun, s_ready}), 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) step();
        payload[0] = 8'h81; payload[1] = 8'h7E;
        run_frame(2, 100, 2, 0, 0);
        chk("t5_clean_bits", obs_val(48), 64'hAAAA_A502_817E);
        chk("t5_clean_done", 64'(n_done), 64'd1);

`ifdef QPSK_CRC_EN
        payload[0] = 8'h00;
        run_frame(1, 100, 1, 0, 0);
        chk("t6_bits_len", 64'(obs.size()), 64'd48);
        chk("t6_bits", obs_val(48), 64'hAAAA_A501_0015);
        chk("t6_done", 64'(n_done), 64'd1);
`endif

        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < 16; i++) payload[i] = 8'($urandom);
            L    = int'($urandom_range(5));
            stop = ($urandom_range(3) == 0) ? int'($urandom_range(L)) : L;
            run_frame(L, int'($urandom_range(55, 100)), stop, 0, 1);
            for (int g = 0; g < int'($urandom_range(6)); g++) step();
            if ($urandom_range(7) == 0) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
